gin_mcast_buffered: RTL

- Next-generation global input network (GIN) for the PE array.
- Accepts tagged words from the GLB side into a FIFO of depth FIFO_DEPTH and matches row_tag/col_tag against scan-loaded per-row and per-PE IDs.
- Delivers each word to every matching PE in one all-or-nothing beat; supports wildcard multicast tags and drops unmatched words with a drop counter.

---
 rtl/gin_mcast_buffered.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gin_mcast_buffered.sv
// Buffered multicast global input network: tagged words are queued, matched against
// scan-loaded row/PE IDs, and delivered to every matching PE in one all-or-nothing beat.
module gin_mcast_buffered #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ROW_TAG_WIDTH = 4,
  parameter int unsigned COL_TAG_WIDTH = 4,
  parameter int unsigned NUM_OF_ROWS   = 12,
  parameter int unsigned NUM_OF_COLS   = 14,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable_in,
  input  logic [DATA_WIDTH-1:0]                data_in,
  input  logic [ROW_TAG_WIDTH-1:0]             row_tag,
  input  logic [COL_TAG_WIDTH-1:0]             col_tag,
  output logic                                 ready_out,
  input  logic [NUM_OF_ROWS*NUM_OF_COLS-1:0]   ready_in,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic [NUM_OF_ROWS*NUM_OF_COLS-1:0]   enable_out,
  input  logic                                 se_id,
  input  logic                                 si_id,
  output logic                                 so_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic [CNT_WIDTH-1:0]                 drop_count
);

  localparam int unsigned NUM_PE  = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int unsigned ROW_IDS = NUM_OF_ROWS * ROW_TAG_WIDTH;
  localparam int unsigned ID_LEN  = ROW_IDS + NUM_PE * COL_TAG_WIDTH;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W = DATA_WIDTH + ROW_TAG_WIDTH + COL_TAG_WIDTH;
  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);

  // ID scan chain
  logic [ID_LEN-1:0] id_chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_chain <= '0;
    end else if (se_id) begin
      id_chain <= {id_chain[ID_LEN-2:0], si_id};
    end
  end

  assign so_id = id_chain[ID_LEN-1];

  // Input FIFO
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;

  assign ready_out = (fifo_count < DEPTH_C);
  assign push      = enable_in && ready_out;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {data_in, row_tag, col_tag};
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head decode and tag match
  logic [ENTRY_W-1:0]       head;
  logic [DATA_WIDTH-1:0]    head_data;
  logic [ROW_TAG_WIDTH-1:0] head_row;
  logic [COL_TAG_WIDTH-1:0] head_col;
  logic [NUM_OF_ROWS-1:0]   row_hit;
  logic [NUM_PE-1:0]        target;
  logic                     row_wild;
  logic                     col_wild;

  assign head      = fifo_mem[rd_ptr];
  assign head_data = head[ENTRY_W-1 -: DATA_WIDTH];
  assign head_row  = head[COL_TAG_WIDTH +: ROW_TAG_WIDTH];
  assign head_col  = head[COL_TAG_WIDTH-1:0];
  assign row_wild  = &head_row;
  assign col_wild  = &head_col;

  always_comb begin
    row_hit = '0;
    target  = '0;
    for (int unsigned r = 0; r < NUM_OF_ROWS; r++) begin
      row_hit[r] = row_wild || (head_row == id_chain[r*ROW_TAG_WIDTH +: ROW_TAG_WIDTH]);
      for (int unsigned c = 0; c < NUM_OF_COLS; c++) begin
        target[r*NUM_OF_COLS + c] = row_hit[r] &&
          (col_wild ||
           (head_col == id_chain[ROW_IDS + (r*NUM_OF_COLS + c)*COL_TAG_WIDTH +: COL_TAG_WIDTH]));
      end
    end
  end

  // Dispatch: drop unmatched heads, deliver only when every target is ready
  logic dispatch_ok;
  logic no_target;
  logic deliver;
  logic drop;

  assign dispatch_ok = (fifo_count != '0) && !se_id;
  assign no_target   = (target == '0);
  assign deliver     = dispatch_ok && !no_target && ((ready_in & target) == target);
  assign drop        = dispatch_ok && no_target;
  assign pop         = deliver || drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_out <= '0;
      data_out   <= '0;
      drop_count <= '0;
    end else begin
      enable_out <= deliver ? target : '0;
      if (deliver) data_out <= head_data;
      if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

endmodule
